pla_sop_engine: RTL and testbench

Programmable, sequential sum-of-products evaluator: a generalised successor to the team's fixed espresso-derived PLA blocks. Instead of a hard-wired cover, it holds a runtime-loadable cube table of N_TERMS product terms over N_IN inputs and N_OUT outputs. It evaluates one input vector per transaction by scanning TERMS_PER_CYC terms per clock. It sits between a configuration master, which loads the cover, and a valid/ready datapath that issues input vectors and consumes results.

---
 rtl/pla_sop_pkg.sv | 23 ++
 rtl/pla_cube_match.sv | 30 +++
 rtl/pla_sop_engine.sv | 137 +++++++++++++
 tb/tb_pla_sop_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_sop_pkg.sv
// Shared constants, state encoding and width helpers for the programmable SOP engine.
package pla_sop_pkg;

  localparam int unsigned DEF_N_IN          = 9;
  localparam int unsigned DEF_N_OUT         = 1;
  localparam int unsigned DEF_N_TERMS       = 64;
  localparam int unsigned DEF_TERMS_PER_CYC = 4;

  localparam logic [1:0] LIT_EMPTY = 2'b00;
  localparam logic [1:0] LIT_ZERO  = 2'b01;
  localparam logic [1:0] LIT_ONE   = 2'b10;
  localparam logic [1:0] LIT_DC    = 2'b11;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_S     = DEF_N_TERMS / DEF_TERMS_PER_CYC;
  localparam int unsigned DEF_PTR_W = clog2_min1(DEF_N_TERMS);

endpackage

// File: rtl/pla_cube_match.sv
// Combinational match of one cube against an input vector; yields the term's output part or 0.
module pla_cube_match
  import pla_sop_pkg::*;
#(
  parameter int unsigned N_IN  = DEF_N_IN,
  parameter int unsigned N_OUT = DEF_N_OUT
) (
  input  logic [2*N_IN-1:0] cube,
  input  logic [N_OUT-1:0]  out,
  input  logic              en,
  input  logic [N_IN-1:0]   x,
  output logic [N_OUT-1:0]  z
);

  logic hit;

  always_comb begin
    hit = en;
    for (int i = 0; i < int'(N_IN); i++) begin
      unique case (cube[2*i +: 2])
        LIT_ZERO:  if (x[i])  hit = 1'b0;
        LIT_ONE:   if (!x[i]) hit = 1'b0;
        LIT_DC:    ;
        default:   hit = 1'b0;
      endcase
    end
    z = hit ? out : '0;
  end

endmodule

// File: rtl/pla_sop_engine.sv
// Runtime-loadable sum-of-products evaluator scanning TERMS_PER_CYC cubes per clock.
// Optional build macro PLA_SOP_EARLY_EXIT_EN ends a scan once the accumulator is all ones.
module pla_sop_engine
  import pla_sop_pkg::*;
#(
  parameter int unsigned N_IN          = DEF_N_IN,
  parameter int unsigned N_OUT         = DEF_N_OUT,
  parameter int unsigned N_TERMS       = DEF_N_TERMS,
  parameter int unsigned TERMS_PER_CYC = DEF_TERMS_PER_CYC,
  localparam int unsigned PTR_W        = clog2_min1(N_TERMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  output logic               cfg_ready,
  input  logic [PTR_W-1:0]   cfg_addr,
  input  logic [2*N_IN-1:0]  cfg_cube,
  input  logic [N_OUT-1:0]   cfg_out,
  input  logic               cfg_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_z,
  output logic               busy
);

  state_e             state_q;
  logic [N_IN-1:0]    x_q;
  logic [N_OUT-1:0]   acc_q, acc_d, hit_or;
  logic [PTR_W-1:0]   ptr_q;
  logic [2*N_IN-1:0]  cube_q [N_TERMS];
  logic [N_OUT-1:0]   tout_q [N_TERMS];
  logic [N_TERMS-1:0] ten_q;
  logic [N_OUT-1:0]   hit [TERMS_PER_CYC];
  logic               last_grp, scan_done, accept, cfg_fire;

  assign busy      = (state_q == StScan);
  assign cfg_ready = !busy;
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign cfg_fire  = cfg_we && cfg_ready;

  // Table is flops rather than RAM so reset can invalidate every term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < int'(N_TERMS); t++) begin
        cube_q[t] <= '0;
        tout_q[t] <= '0;
      end
      ten_q <= '0;
    end else if (cfg_fire) begin
      cube_q[cfg_addr] <= cfg_cube;
      tout_q[cfg_addr] <= cfg_out;
      ten_q[cfg_addr]  <= cfg_en;
    end
  end

  for (genvar j = 0; j < int'(TERMS_PER_CYC); j++) begin : g_match
    logic [PTR_W-1:0] idx;
    assign idx = ptr_q + PTR_W'(j);
    pla_cube_match #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT)
    ) u_match (
      .cube (cube_q[idx]),
      .out  (tout_q[idx]),
      .en   (ten_q[idx]),
      .x    (x_q),
      .z    (hit[j])
    );
  end

  always_comb begin
    hit_or = '0;
    for (int j = 0; j < int'(TERMS_PER_CYC); j++) begin
      hit_or = hit_or | hit[j];
    end
    acc_d = acc_q | hit_or;
  end

  assign last_grp = (ptr_q == PTR_W'(N_TERMS - TERMS_PER_CYC));

`ifdef PLA_SOP_EARLY_EXIT_EN
  assign scan_done = last_grp || (&acc_d);
`else
  assign scan_done = last_grp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_q       <= '0;
      acc_q     <= '0;
      ptr_q     <= '0;
      out_z     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            x_q     <= in_x;
            acc_q   <= '0;
            ptr_q   <= '0;
            state_q <= StScan;
          end
        end
        StScan: begin
          acc_q <= acc_d;
          ptr_q <= ptr_q + PTR_W'(TERMS_PER_CYC);
          if (scan_done) begin
            out_z     <= acc_d;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              // Back-to-back accept: next scan starts with no idle bubble.
              x_q     <= in_x;
              acc_q   <= '0;
              ptr_q   <= '0;
              state_q <= StScan;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_sop_engine.sv
// Randomized and directed bench for pla_sop_engine against a term-list reference model.
module tb_pla_sop_engine;

  localparam int N_IN = 9;
  localparam int N_OUT = 1;
  localparam int N_TERMS = 64;
  localparam int TPC = 4;
  localparam int S = N_TERMS / TPC;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic              cfg_ready;
  logic [5:0]        cfg_addr;
  logic [2*N_IN-1:0] cfg_cube;
  logic [N_OUT-1:0]  cfg_out;
  logic              cfg_en;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_x;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_z;
  logic              busy;

  int n_checks = 0;
  int n_fail = 0;

  logic [2*N_IN-1:0] m_cube [N_TERMS];
  logic [N_OUT-1:0]  m_out [N_TERMS];
  bit                m_en [N_TERMS];

  logic [N_OUT-1:0] exp_z;
  int               exp_lat;

  pla_sop_engine u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_cube  (cfg_cube),
    .cfg_out   (cfg_out),
    .cfg_en    (cfg_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: OR of every valid term whose literals all accept x; latency from group order.
  function automatic int model_eval(input logic [N_IN-1:0] x, output logic [N_OUT-1:0] z);
    z = '0;
    for (int g = 0; g < S; g++) begin
      for (int j = 0; j < TPC; j++) begin
        int t;
        bit ok;
        t = g * TPC + j;
        ok = m_en[t];
        for (int i = 0; i < N_IN; i++) begin
          logic [1:0] lit;
          lit = m_cube[t][2*i +: 2];
          if (lit == 2'b00) ok = 0;
          else if (lit != 2'b11 && x[i] != lit[1]) ok = 0;
        end
        if (ok) z = z | m_out[t];
      end
`ifdef PLA_SOP_EARLY_EXIT_EN
      if (&z) return g + 1;
`endif
    end
    return S;
  endfunction

  function automatic logic [2*N_IN-1:0] rand_cube();
    logic [2*N_IN-1:0] c;
    for (int i = 0; i < N_IN; i++) begin
      int r;
      r = $urandom_range(0, 9);
      c[2*i +: 2] = (r == 0) ? 2'b00 : (r < 3) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
    end
    return c;
  endfunction

  task automatic cfg_write(input logic [5:0] a, input logic [2*N_IN-1:0] c,
                           input logic [N_OUT-1:0] o, input logic e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_cube = c; cfg_out = o; cfg_en = e;
    check_eq("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    m_cube[a] = c; m_out[a] = o; m_en[a] = e;
    #1 cfg_we = 1'b0;
  endtask

  task automatic start_vec(input logic [N_IN-1:0] x);
    exp_lat = model_eval(x, exp_z);
    @(negedge clk);
    in_valid = 1'b1; in_x = x;
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accept edge; k counts edges past it.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < S + 4) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check_eq({tag, "_z"}, 32'(out_z), 32'(exp_z));
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_vec(input logic [N_IN-1:0] x, input string tag);
    start_vec(x);
    wait_done(tag);
    pop();
  endtask

  initial begin
    logic [2*N_IN-1:0] c5;
    logic [2*N_IN-1:0] c63;
    logic [N_OUT-1:0]  z0;
    int                n;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_cube = '0; cfg_out = '0; cfg_en = 1'b0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    for (int t = 0; t < N_TERMS; t++) begin
      m_cube[t] = '0; m_out[t] = '0; m_en[t] = 0;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_z", 32'(out_z), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;

    // Empty table: full-length scan, result 0.
    run_vec(9'h1FF, "empty");

    c5 = '1; c5[5:4] = 2'b10; c5[9:8] = 2'b10;
    cfg_write(6'd5, c5, 1'b1, 1'b1);
    run_vec(9'h014, "t5_hit");
    run_vec(9'h010, "t5_miss");

    // Empty literal in term 63 must block every vector.
    cfg_write(6'd5, c5, 1'b1, 1'b0);
    c63 = '1; c63[1:0] = 2'b00;
    cfg_write(6'd63, c63, 1'b1, 1'b1);
    for (int v = 0; v < 512; v++) begin
      run_vec(N_IN'(v), "empty_lit");
    end

    // Backpressure in DONE, then back-to-back accept.
    start_vec(9'h0AA);
    wait_done("bp");
    for (int i = 0; i < 5; i++) begin
      z0 = out_z;
      @(negedge clk);
      check_eq("bp_z_stable", 32'(out_z), 32'(z0));
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    end
    exp_lat = model_eval(9'h155, exp_z);
    in_valid = 1'b1; in_x = 9'h155; out_ready = 1'b1;
    #1 check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    check_eq("b2b_busy", 32'(busy), 32'd1);
    check_eq("b2b_out_valid", 32'(out_valid), 32'd0);
    wait_done("b2b");
    pop();

    // Write attempted mid-scan is held off until DONE.
    start_vec(9'h033);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_cube = '1; cfg_out = 1'b1; cfg_en = 1'b1;
    n = 0;
    while (!out_valid && n < S + 4) begin
      check_eq("cfg_held_off", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check_eq("cfg_scan_valid", 32'(out_valid), 32'd1);
    check_eq("cfg_scan_z", 32'(out_z), 32'(exp_z));
    check_eq("cfg_ready_done", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    m_cube[0] = '1; m_out[0] = 1'b1; m_en[0] = 1;
    #1 cfg_we = 1'b0;
    pop();
    run_vec(9'h033, "cfg_landed");

    // Reset mid-scan discards the transaction and invalidates the table.
    cfg_write(6'd0, '1, 1'b1, 1'b0);
    c63 = '1; c63[5:4] = 2'b10; c63[9:8] = 2'b10;
    cfg_write(6'd63, c63, 1'b1, 1'b1);
    start_vec(9'h014);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < N_TERMS; t++) m_en[t] = 0;
    n = 0;
    repeat (S + 8) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check_eq("mid_rst_no_output", 32'(n), 32'd0);
    run_vec(9'h014, "post_rst");

    // Random cover and vectors.
    for (int i = 0; i < 16; i++) begin
      cfg_write(6'($urandom_range(0, N_TERMS - 1)), rand_cube(), N_OUT'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 60; i++) begin
      run_vec(N_IN'($urandom_range(0, 511)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
